calc_entry_fsm: RTL and testbench
=================================

Name: calc_entry_fsm

Overview:
- Keypad-entry controller for the VGA calculator.
- Consumes the grid cell code under the cursor and the debounced centre-button pulse.
- Builds operand 1, operator and operand 2, executes the operation, and drives what calculator_screen displays: input_screen, op1, op2, op.
- Sits between grid_cursor/debouncers and calculator_screen.

Parameters:
- WIDTH, 16, operand/result width in bits.

Ports:
- clk  input  1  system clock (CLK100MHZ domain).
- rst  input  1  synchronous, active-high reset.
- val  input  5  grid cell code under the cursor (from grid_cursor).
- enter_button  input  1  one-cycle pulse (debounced posedge); samples val.
- mode  input  1  0 = decimal entry, 1 = hex entry.
- input_screen  output  WIDTH  value shown on the main entry screen.
- op1  output  WIDTH  latched operand 1.
- op2  output  WIDTH  latched operand 2.
- op  output  3  operator: 0 none, 1 add, 2 sub, 3 mul, 4 and, 5 or.
- result_valid  output  1  high while the shown value is a computed result.
- overflow  output  1  last mul result exceeded WIDTH bits.
- negative  output  1  last sub borrowed (op1 < op2).

Behaviour:
- Key codes on val:
  - 0-15: digit 0x0-0xF.
  - 16 add, 17 sub, 18 mul, 19 and, 20 or.
  - 21 CE (clear entry), 22 AC (all clear), 23 EQ (execute).
  - 24-31: ignored.
- Only enter_button cycles act. Without enter_button, all registers hold.
- All outputs are registered; a key pulsed in cycle t is visible in cycle t+1.
- Reset and all-clear: every output 0, op = 0, state ENTER_OP1.
- States: ENTER_OP1, ENTER_OP2, EXEC, SHOW_RESULT.
- Digit accumulation into acc (op1 or op2):
  - hex mode: acc = {acc[WIDTH-5:0], d}; key ignored if acc[WIDTH-1:WIDTH-4] != 0.
  - decimal mode: acc = acc*10 + d; key ignored if d > 9 or the result would exceed 2^WIDTH-1.
  - An ignored key changes nothing.
- ENTER_OP1:
  - digit: accumulate into op1.
  - operator: op = code, op2 = 0, go to ENTER_OP2.
  - CE: op1 = 0.
  - AC: all clear.
  - EQ: ignored.
- ENTER_OP2:
  - digit: accumulate into op2.
  - operator: replace op; op2 unchanged.
  - CE: op2 = 0.
  - AC: all clear.
  - EQ: go to EXEC.
- EXEC (exactly one cycle; enter_button ignored):
  - add: (op1+op2) mod 2^WIDTH.
  - sub: (op1-op2) mod 2^WIDTH; negative = (op1 < op2).
  - mul: low WIDTH bits of op1*op2; overflow = upper bits nonzero.
  - and/or: bitwise.
  - Result, negative and overflow registered; go to SHOW_RESULT.
  - Flags not produced by the executed op are cleared.
- SHOW_RESULT (result_valid = 1):
  - digit: op1 = digit, op2 = 0, op = 0, flags cleared, go to ENTER_OP1. A digit invalid in the current mode is ignored.
  - operator (chaining): op1 = result, op2 = 0, op = code, go to ENTER_OP2.
  - EQ: ignored.
  - CE or AC: all clear.
- input_screen source by state:
  - ENTER_OP1: op1.
  - ENTER_OP2: op2.
  - EXEC: holds its previous value.
  - SHOW_RESULT: result.
- EQ at cycle t: EXEC at t+1, result on input_screen and result_valid = 1 at t+2.
- Mode change (mode differs from its registered copy) performs all-clear on the next cycle. It takes priority over a simultaneous enter_button.
- rst in any state, including EXEC, overrides everything and yields the reset values next cycle.

Test Plan:
- mode=1; keys 1, 2, A, add, 3, EQ -> op1 = 0x012A, op = 1, op2 = 0x0003; two cycles after EQ, input_screen = 0x012D, result_valid = 1.
- mode=0; keys 6, 5, 5, 3, 5, 5 -> op1 = 65535; the final 5 and key A are ignored, op1 stays 0xFFFF.
- mode=1; keys 3, sub, 5, EQ -> input_screen = 0xFFFE, negative = 1; then add, 2, EQ -> input_screen = 0x0000, negative = 0.
- mode=1; keys 1, 0, 0, mul, 1, 0, 0, EQ -> input_screen = 0x0000, overflow = 1; then digit 7 -> op1 = 0x0007, op = 0, overflow = 0, state ENTER_OP1.
- Pulse rst during EXEC, then toggle mode mid-entry of op2 -> next cycle all outputs 0, op = 0, result_valid = 0; an EQ pulse in the toggle cycle has no effect.
- Keys 4, and, CE, or, 6, EQ with mode=1 -> op = 5, input_screen = 0x0006; enter pulses with val = 25 change no output.

Source files
------------

// File: rtl/calc_entry_fsm.sv
// Keypad-entry controller for the VGA calculator: builds op1/op/op2 from grid key
// presses, executes on EQ and drives the values shown by calculator_screen.
module calc_entry_fsm #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       val,
    input  logic             enter_button,
    input  logic             mode,
    output logic [WIDTH-1:0] input_screen,
    output logic [WIDTH-1:0] op1,
    output logic [WIDTH-1:0] op2,
    output logic [2:0]       op,
    output logic             result_valid,
    output logic             overflow,
    output logic             negative
);

    typedef enum logic [1:0] {ENTER_OP1, ENTER_OP2, EXEC, SHOW_RESULT} state_t;

    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_MUL = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;

    state_t state;
    logic   mode_q;

    // Returns {accepted, new_acc}; a rejected key must leave acc untouched.
    function automatic logic [WIDTH:0] accumulate(input logic [WIDTH-1:0] acc,
                                                  input logic [3:0] d, input logic hex);
        logic [WIDTH+3:0] wide;
        if (hex) begin
            accumulate = {(acc[WIDTH-1:WIDTH-4] == 4'd0), acc[WIDTH-5:0], d};
        end else begin
            wide = {4'd0, acc} * (WIDTH+4)'(10) + {{WIDTH{1'b0}}, d};
            accumulate = {(d <= 4'd9) && (wide[WIDTH+3:WIDTH] == 4'd0), wide[WIDTH-1:0]};
        end
    endfunction

    logic             key_digit, key_oper, key_ce, key_ac, key_eq;
    logic [2:0]       oper_code;
    logic [WIDTH:0]   acc1, acc2, acc_new;
    logic             do_clear;

    assign key_digit = ~val[4];
    assign key_oper  = (val >= 5'd16) && (val <= 5'd20);
    assign key_ce    = (val == 5'd21);
    assign key_ac    = (val == 5'd22);
    assign key_eq    = (val == 5'd23);
    assign oper_code = val[2:0] + 3'd1;   // 16..20 -> 1..5

    assign acc1    = accumulate(op1, val[3:0], mode);
    assign acc2    = accumulate(op2, val[3:0], mode);
    assign acc_new = accumulate('0, val[3:0], mode);

    // Mode switch wipes the entry so a half-typed number is never reinterpreted.
    assign do_clear = rst || (mode != mode_q) ||
                      (enter_button && (state != EXEC) &&
                       (key_ac || (state == SHOW_RESULT && key_ce)));

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   exec_res;
    logic               exec_neg, exec_ovf;

    assign prod = op1 * op2;
    assign diff = {1'b0, op1} - {1'b0, op2};

    always_comb begin
        exec_res = '0;
        exec_neg = 1'b0;
        exec_ovf = 1'b0;
        case (op)
            OP_ADD: exec_res = op1 + op2;
            OP_SUB: begin
                exec_res = diff[WIDTH-1:0];
                exec_neg = diff[WIDTH];
            end
            OP_MUL: begin
                exec_res = prod[WIDTH-1:0];
                exec_ovf = |prod[2*WIDTH-1:WIDTH];
            end
            OP_AND:  exec_res = op1 & op2;
            OP_OR:   exec_res = op1 | op2;
            default: exec_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        mode_q <= mode;
        if (do_clear) begin
            state        <= ENTER_OP1;
            input_screen <= '0;
            op1          <= '0;
            op2          <= '0;
            op           <= 3'd0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
            negative     <= 1'b0;
        end else begin
            case (state)
                ENTER_OP1: if (enter_button) begin
                    if (key_digit && acc1[WIDTH]) begin
                        op1          <= acc1[WIDTH-1:0];
                        input_screen <= acc1[WIDTH-1:0];
                    end else if (key_oper) begin
                        op           <= oper_code;
                        op2          <= '0;
                        input_screen <= '0;
                        state        <= ENTER_OP2;
                    end else if (key_ce) begin
                        op1          <= '0;
                        input_screen <= '0;
                    end
                end
                ENTER_OP2: if (enter_button) begin
                    if (key_digit && acc2[WIDTH]) begin
                        op2          <= acc2[WIDTH-1:0];
                        input_screen <= acc2[WIDTH-1:0];
                    end else if (key_oper) begin
                        op <= oper_code;
                    end else if (key_ce) begin
                        op2          <= '0;
                        input_screen <= '0;
                    end else if (key_eq) begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    input_screen <= exec_res;
                    negative     <= exec_neg;
                    overflow     <= exec_ovf;
                    result_valid <= 1'b1;
                    state        <= SHOW_RESULT;
                end
                SHOW_RESULT: if (enter_button) begin
                    // input_screen holds the result here, so it seeds a chained op.
                    if (key_digit && acc_new[WIDTH]) begin
                        op1          <= acc_new[WIDTH-1:0];
                        op2          <= '0;
                        op           <= 3'd0;
                        input_screen <= acc_new[WIDTH-1:0];
                        result_valid <= 1'b0;
                        overflow     <= 1'b0;
                        negative     <= 1'b0;
                        state        <= ENTER_OP1;
                    end else if (key_oper) begin
                        op1          <= input_screen;
                        op2          <= '0;
                        op           <= oper_code;
                        input_screen <= '0;
                        result_valid <= 1'b0;
                        state        <= ENTER_OP2;
                    end
                end
                default: state <= ENTER_OP1;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Bench for calc_entry_fsm: directed key sequences then random pulses, every cycle
// compared against an arithmetic calculator model.
module tb_calc_entry_fsm;
    logic        clk = 1'b0;
    logic        rst, enter_button, mode;
    logic [4:0]  val;
    logic [15:0] input_screen, op1, op2;
    logic [2:0]  op;
    logic        result_valid, overflow, negative;

    calc_entry_fsm #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .val(val), .enter_button(enter_button), .mode(mode),
        .input_screen(input_screen), .op1(op1), .op2(op2), .op(op),
        .result_valid(result_valid), .overflow(overflow), .negative(negative)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0, fail_cnt = 0, total_cnt = 0;
    bit md = 1'b1;

    // model: phase 0 entering op1, 1 entering op2, 2 computing, 3 showing result
    int  m_phase, m_op1, m_op2, m_op, m_scr;
    bit  m_rv, m_ov, m_neg, m_mode;

    task automatic m_clear();
        m_phase = 0; m_op1 = 0; m_op2 = 0; m_op = 0; m_scr = 0;
        m_rv = 0; m_ov = 0; m_neg = 0;
    endtask

    function automatic bit digit_ok(int acc, int d, bit hex);
        if (hex) return acc < 4096;
        return (d <= 9) && (acc * 10 + d <= 65535);
    endfunction

    function automatic int digit_add(int acc, int d, bit hex);
        return hex ? (acc * 16 + d) % 65536 : acc * 10 + d;
    endfunction

    task automatic model_step(input bit r, input bit e, input int v, input bit hx);
        longint a, b, p;
        if (r || hx != m_mode) begin
            m_clear();
            m_mode = hx;
            return;
        end
        if (m_phase == 2) begin
            a = m_op1; b = m_op2;
            m_neg = 0; m_ov = 0;
            case (m_op)
                1: m_scr = int'((a + b) % 65536);
                2: begin m_scr = int'((a - b + 65536) % 65536); m_neg = (a < b); end
                3: begin p = a * b; m_scr = int'(p % 65536); m_ov = (p > 65535); end
                4: m_scr = int'(a & b);
                5: m_scr = int'(a | b);
                default: m_scr = 0;
            endcase
            m_rv = 1; m_phase = 3;
            return;
        end
        if (!e) return;
        if (v == 22 || (m_phase == 3 && v == 21)) begin
            m_clear();
            return;
        end
        case (m_phase)
            0: begin
                if (v < 16) begin
                    if (digit_ok(m_op1, v, hx)) begin
                        m_op1 = digit_add(m_op1, v, hx); m_scr = m_op1;
                    end
                end else if (v <= 20) begin
                    m_op = v - 15; m_op2 = 0; m_scr = 0; m_phase = 1;
                end else if (v == 21) begin
                    m_op1 = 0; m_scr = 0;
                end
            end
            1: begin
                if (v < 16) begin
                    if (digit_ok(m_op2, v, hx)) begin
                        m_op2 = digit_add(m_op2, v, hx); m_scr = m_op2;
                    end
                end else if (v <= 20) begin
                    m_op = v - 15;
                end else if (v == 21) begin
                    m_op2 = 0; m_scr = 0;
                end else if (v == 23) begin
                    m_phase = 2;
                end
            end
            default: begin
                if (v < 16) begin
                    if (digit_ok(0, v, hx)) begin
                        m_op1 = v; m_op2 = 0; m_op = 0; m_scr = v;
                        m_rv = 0; m_ov = 0; m_neg = 0; m_phase = 0;
                    end
                end else if (v <= 20) begin
                    m_op1 = m_scr; m_op2 = 0; m_op = v - 15; m_scr = 0;
                    m_rv = 0; m_phase = 1;
                end
            end
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        assert (got === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_model();
        check("screen", 32'(input_screen), 32'(m_scr));
        check("op1", 32'(op1), 32'(m_op1));
        check("op2", 32'(op2), 32'(m_op2));
        check("op", 32'(op), 32'(m_op));
        check("result_valid", 32'(result_valid), 32'(m_rv));
        check("overflow", 32'(overflow), 32'(m_ov));
        check("negative", 32'(negative), 32'(m_neg));
    endtask

    task automatic step(input bit r, input bit e, input int v);
        rst = r; enter_button = e; val = 5'(v); mode = md;
        @(posedge clk);
        model_step(r, e, v, md);
        #1;
        check_model();
    endtask

    task automatic key(input int v);
        step(0, 1, v);
    endtask

    task automatic idle();
        step(0, 0, int'($urandom_range(0, 31)));
    endtask

    initial begin
        m_clear();
        m_mode = md;
        step(1, 0, 0);
        step(1, 1, 5);
        check("reset_screen", 32'(input_screen), 32'h0);
        check("reset_op", 32'(op), 32'h0);
        check("reset_rv", 32'(result_valid), 32'h0);

        // hex add
        key(1); key(2); key(10); key(16); key(3);
        check("hex_op1", 32'(op1), 32'h012A);
        check("hex_op", 32'(op), 32'd1);
        check("hex_op2", 32'(op2), 32'h0003);
        key(23); idle();
        check("add_result", 32'(input_screen), 32'h012D);
        check("add_rv", 32'(result_valid), 32'd1);

        // decimal saturation boundary
        md = 1'b0; idle();
        key(6); key(5); key(5); key(3); key(5); key(5); key(10);
        check("dec_max", 32'(op1), 32'hFFFF);

        // subtract with borrow, then chain an add
        md = 1'b1; idle();
        key(3); key(17); key(5); key(23); idle();
        check("sub_result", 32'(input_screen), 32'hFFFE);
        check("sub_neg", 32'(negative), 32'd1);
        key(16); key(2); key(23); idle();
        check("chain_result", 32'(input_screen), 32'h0000);
        check("chain_neg", 32'(negative), 32'd0);

        // multiply overflow, then a digit restarts entry
        key(22);
        key(1); key(0); key(0); key(18); key(1); key(0); key(0); key(23); idle();
        check("mul_result", 32'(input_screen), 32'h0000);
        check("mul_ovf", 32'(overflow), 32'd1);
        key(7);
        check("restart_op1", 32'(op1), 32'h0007);
        check("restart_op", 32'(op), 32'd0);
        check("restart_ovf", 32'(overflow), 32'd0);
        check("restart_rv", 32'(result_valid), 32'd0);

        // reset during EXEC, then mode toggle beating a simultaneous EQ
        key(1); key(16); key(2); key(23);
        step(1, 0, 0);
        check("rst_exec_op", 32'(op), 32'd0);
        check("rst_exec_rv", 32'(result_valid), 32'd0);
        key(4); key(16); key(5);
        md = 1'b0; key(23);
        check("toggle_screen", 32'(input_screen), 32'h0);
        check("toggle_op2", 32'(op2), 32'h0);
        check("toggle_rv", 32'(result_valid), 32'd0);

        // CE, operator replacement, ignored codes
        md = 1'b1; idle();
        key(4); key(19); key(21); key(20); key(6); key(23); idle();
        check("or_op", 32'(op), 32'd5);
        check("or_result", 32'(input_screen), 32'h0006);
        key(25); key(25);
        check("ignored_screen", 32'(input_screen), 32'h0006);

        for (int i = 0; i < 400; i++) begin
            int v;
            if ($urandom_range(0, 39) == 0) md = ~md;
            v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(16, 31))
                                              : int'($urandom_range(0, 15));
            step($urandom_range(0, 59) == 0, 1'($urandom_range(0, 1)), v);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
